// File: rtl/mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store unit between a pipeline request port and a
//               single-ported combinational-read data memory. Handles word
//               accesses directly. Sub-word stores use read-modify-write.
//               Misaligned, illegal-size and out-of-range requests get an
//               error response and never touch the memory.
//               Optional feature macro: MAU_SUBWORD_EN (byte/halfword access).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [31:0] Adress,
  output logic [31:0] WriteD,
  input  logic [31:0] Rdata
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RD   = 2'd1;
  localparam logic [1:0] c_WR   = 2'd2;
  localparam logic [1:0] c_RESP = 2'd3;

  localparam logic [1:0] c_SZ_BYTE = 2'd0;
  localparam logic [1:0] c_SZ_HALF = 2'd1;
  localparam logic [1:0] c_SZ_WORD = 2'd2;

  logic [1:0] r_state;
  logic       w_misalign;
  logic       w_bad_size;
  logic       w_out_of_range;
  logic       w_err;

  assign req_ready      = (r_state == c_IDLE);
  // Word index at or beyond DEPTH is the same as byte address >= 4*DEPTH
  assign w_out_of_range = (req_addr[31:2] >= 30'(DEPTH));
  assign w_err          = w_misalign | w_bad_size | w_out_of_range;

`ifdef MAU_SUBWORD_EN
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_sign;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata_lo;

  // Alignment and size legality for byte/half/word requests
  always_comb begin
    w_misalign = 1'b0;
    w_bad_size = 1'b0;
    case (req_size)
      c_SZ_BYTE: w_misalign = 1'b0;
      c_SZ_HALF: w_misalign = req_addr[0];
      c_SZ_WORD: w_misalign = (req_addr[1:0] != 2'b00);
      default:   w_bad_size = 1'b1;
    endcase
  end

  // Select the addressed lane of a memory word and extend it
  function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] lane, input logic sign);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      c_SZ_BYTE: f_extract = sign ? {{24{b[7]}}, b} : {24'h0, b};
      c_SZ_HALF: f_extract = sign ? {{16{h[15]}}, h} : {16'h0, h};
      default:   f_extract = word;
    endcase
  endfunction

  // Replace only the addressed lane, keeping the other bytes of the old word
  function automatic logic [31:0] f_merge(input logic [31:0] word, input logic [15:0] wd,
                                          input logic [1:0] size, input logic [1:0] lane);
    f_merge = word;
    if (size == c_SZ_BYTE) begin
      f_merge[{lane, 3'b000} +: 8] = wd[7:0];
    end else if (lane[1]) begin
      f_merge[31:16] = wd;
    end else begin
      f_merge[15:0] = wd;
    end
  endfunction
`else
  logic w_unused_sign;
  assign w_unused_sign = req_sign;
  // Only aligned word accesses exist in this build
  assign w_bad_size = (req_size != c_SZ_WORD);
  assign w_misalign = (req_addr[1:0] != 2'b00);
`endif

  // Control FSM with registered memory strobes and response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
      MemWrite   <= 1'b0;
      MemRead    <= 1'b0;
      Adress     <= 32'h0;
      WriteD     <= 32'h0;
`ifdef MAU_SUBWORD_EN
      r_write    <= 1'b0;
      r_size     <= c_SZ_WORD;
      r_sign     <= 1'b0;
      r_lane     <= 2'b00;
      r_wdata_lo <= 16'h0;
`endif
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (req_valid) begin
            Adress <= {2'b00, req_addr[31:2]};
`ifdef MAU_SUBWORD_EN
            r_write    <= req_write;
            r_size     <= req_size;
            r_sign     <= req_sign;
            r_lane     <= req_addr[1:0];
            r_wdata_lo <= req_wdata[15:0];
`endif
            if (w_err) begin
              r_state    <= c_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_write && (req_size == c_SZ_WORD)) begin
              r_state <= c_WR;
              MemRead <= 1'b1;
              WriteD  <= req_wdata;
            end else begin
              r_state  <= c_RD;
              MemWrite <= 1'b1;
            end
          end
        end
        c_RD: begin
          MemWrite <= 1'b0;
`ifdef MAU_SUBWORD_EN
          if (r_write) begin
            r_state <= c_WR;
            MemRead <= 1'b1;
            WriteD  <= f_merge(Rdata, r_wdata_lo, r_size, r_lane);
          end else begin
            r_state    <= c_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= f_extract(Rdata, r_size, r_lane, r_sign);
          end
`else
          r_state    <= c_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= Rdata;
`endif
        end
        c_WR: begin
          MemRead    <= 1'b0;
          r_state    <= c_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit. A byte-array reference
//               model predicts each response; a monitor compares responses,
//               strobe counts, addresses and committed store words.
//               Honours MAU_SUBWORD_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);
  localparam int P     = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd2;
  logic        req_sign = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Adress;
  logic [31:0] WriteD;
  logic [31:0] Rdata;

  always #(P/2) clk = ~clk;

  mem_access_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_sign(req_sign),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .MemWrite(MemWrite),
    .MemRead(MemRead), .Adress(Adress), .WriteD(WriteD), .Rdata(Rdata)
  );

  // Attached data memory: MemWrite selects read-out, MemRead commits WriteD
  logic [31:0]   mem [DEPTH];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_idx = '0;
  logic [31:0]   pre_val = 32'h0;

  always @(posedge clk) begin
    if (MemRead && (Adress < 32'(DEPTH))) mem[Adress[AW-1:0]] <= WriteD;
    else if (pre_we) mem[pre_idx] <= pre_val;
  end
  assign Rdata = (Adress < 32'(DEPTH)) ? mem[Adress[AW-1:0]] : 32'h0;

  // Reference model state: memory as little-endian bytes
  logic [7:0] rb [4*DEPTH];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wd;
    logic [31:0] adr;
    time         t_acc;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int n_issued = 0;
  int n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int idx);
    ref_word = {rb[4*idx+3], rb[4*idx+2], rb[4*idx+1], rb[4*idx]};
  endfunction

  task automatic preset(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_we  = 1'b1;
    pre_idx = AW'(idx);
    pre_val = val;
    @(posedge clk);
    #1 pre_we = 1'b0;
    for (int b = 0; b < 4; b++) rb[4*idx+b] = val[8*b +: 8];
  endtask

  // Predict the outcome of one request from the byte-level rules
  task automatic model(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd, output exp_t e);
    int n;
    int base;
    logic legal;
    logic [31:0] v;
    n = 1 << sz;
    legal = (sz != 2'd3) && ((ad % n) == 0) && (ad < 32'(4*DEPTH));
`ifndef MAU_SUBWORD_EN
    legal = legal && (sz == 2'd2);
`endif
    e.rdata = 32'h0; e.err = !legal; e.lat = 1; e.nrd = 0; e.nwr = 0;
    e.wd = 32'h0; e.adr = {2'b00, ad[31:2]}; e.t_acc = 0;
    if (legal) begin
      base = int'(ad);
      if (!wr) begin
        v = 32'h0;
        for (int b = 0; b < n; b++) v = v | (32'(rb[base+b]) << (8*b));
        if (sg && (n < 4) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        e.rdata = v; e.lat = 2; e.nrd = 1;
      end else begin
        for (int b = 0; b < n; b++) rb[base+b] = 8'(wd >> (8*b));
        e.wd  = ref_word(base / 4);
        e.nwr = 1;
        e.nrd = (n == 4) ? 0 : 1;
        e.lat = (n == 4) ? 2 : 3;
      end
    end
  endtask

  // Present one request, then keep junk on the bus until it completes
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd);
    exp_t e;
    int k;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); #1; k++; end
    chk("ready_wait", 32'(req_ready), 32'h1);
    model(wr, sz, sg, ad, wd, e);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_sign = sg;
    req_addr = ad; req_wdata = wd;
    @(posedge clk);
    e.t_acc = $time;
    sbq.push_back(e);
    n_issued++;
    #1;
    k = 0;
    while (n_done != n_issued && k < 50) begin
      req_valid = 1'b1; req_write = 1'($urandom); req_size = 2'($urandom);
      req_sign = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      @(negedge clk); #1; k++;
    end
    req_valid = 1'b0;
    chk("resp_wait", 32'(n_done), 32'(n_issued));
    if (n_done != n_issued) begin sbq.delete(); n_done = n_issued; end
  endtask

  // Monitor: strobe accounting, response scoreboard, output hold
  int          nrd_s = 0;
  int          nwr_s = 0;
  logic [31:0] adr_rd = 32'h0;
  logic [31:0] adr_wr = 32'h0;
  logic [31:0] wd_s = 32'h0;
  logic [31:0] last_rdata = 32'h0;
  logic        last_err = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      nrd_s = 0; nwr_s = 0; last_rdata = 32'h0; last_err = 1'b0;
    end else begin
      if (MemWrite || MemRead) chk("strobe_excl", 32'(MemWrite & MemRead), 32'h0);
      if (MemWrite) begin nrd_s++; adr_rd = Adress; end
      if (MemRead) begin nwr_s++; adr_wr = Adress; wd_s = WriteD; end
      if (resp_valid) begin
        chk("resp_strobes", 32'(MemWrite | MemRead), 32'h0);
        if (sbq.size() == 0) begin
          chk("unexpected_resp", 32'(resp_valid), 32'h0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rdata", resp_rdata, e.rdata);
          chk("err", 32'(resp_err), 32'(e.err));
          chk("latency", 32'(int'(($time - e.t_acc + 5) / P)), 32'(e.lat));
          chk("rd_strobes", 32'(nrd_s), 32'(e.nrd));
          chk("wr_strobes", 32'(nwr_s), 32'(e.nwr));
          if (e.nrd != 0) chk("rd_adress", adr_rd, e.adr);
          if (e.nwr != 0) begin
            chk("wr_adress", adr_wr, e.adr);
            chk("writed", wd_s, e.wd);
          end
          last_rdata = e.rdata;
          last_err   = e.err;
          n_done++;
        end
        nrd_s = 0; nwr_s = 0;
      end else begin
        chk("hold_rdata", resp_rdata, last_rdata);
        chk("hold_err", 32'(resp_err), 32'(last_err));
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_err", 32'(resp_err), 32'h0);
    chk("rst_strobes", {30'h0, MemWrite, MemRead}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_adress", Adress, 32'h0);
    chk("rst_writed", WriteD, 32'h0);
    for (int i = 0; i < DEPTH; i++) preset(i, $urandom);
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk); #1;

    // Word store then word load at 0x08
    issue(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEAD_BEEF);
    chk("mem2_word_store", mem[2], 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
`ifdef MAU_SUBWORD_EN
    preset(2, 32'h1122_3344);
    issue(1'b1, 2'd0, 1'b0, 32'h09, 32'h0000_00AA);
    chk("mem2_byte_rmw", mem[2], 32'h1122_AA44);
    preset(2, 32'h80FF_7F01);
    issue(1'b0, 2'd0, 1'b1, 32'h0A, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h0A, 32'h0);
    issue(1'b0, 2'd0, 1'b1, 32'h08, 32'h0);
`else
    issue(1'b0, 2'd0, 1'b0, 32'h00, 32'h0);
`endif
    // Misaligned and first out-of-range word
    issue(1'b0, 2'd2, 1'b0, 32'h06, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'(4*DEPTH), 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'(4*DEPTH - 4), 32'h0BAD_F00D);

    // Reset during the read cycle of an access
    while (!req_ready) begin @(negedge clk); #1; end
    req_valid = 1'b1; req_sign = 1'b0; req_addr = 32'h11; req_wdata = 32'h55;
`ifdef MAU_SUBWORD_EN
    req_write = 1'b1; req_size = 2'd0;
`else
    req_write = 1'b0; req_size = 2'd2; req_addr = 32'h10;
`endif
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_rd_strobe", 32'(MemWrite), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_strobes", {30'h0, MemWrite, MemRead}, 32'h0);
    chk("abort_ready", 32'(req_ready), 32'h1);
    @(negedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("post_abort_valid", 32'(resp_valid), 32'h0);
      chk("post_abort_strobes", {30'h0, MemWrite, MemRead}, 32'h0);
      chk("post_abort_ready", 32'(req_ready), 32'h1);
    end

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 7))
        0:       a = 32'(4*DEPTH) + 32'($urandom_range(0, 12));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, 4*DEPTH - 1));
      endcase
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
    end

    @(negedge clk); #1;
    for (int i = 0; i < DEPTH; i++) chk("final_mem", mem[i], ref_word(i));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
